// File: rtl/imm_encoder_if.sv
// Request/result bundle for the immediate encoder: the master issues Start/Value/ImmSrc,
// the slave returns Busy/Done and the encoded Field with its Valid flag.
interface imm_encoder_if;
    logic        Start;
    logic [31:0] Value;
    logic [1:0]  ImmSrc;
    logic        Busy;
    logic        Done;
    logic        Valid;
    logic [23:0] Field;

    modport master (
        output Start, Value, ImmSrc,
        input  Busy, Done, Valid, Field
    );

    modport slave (
        input  Start, Value, ImmSrc,
        output Busy, Done, Valid, Field
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit constant into the Instr[23:0] immediate field for the selected ImmSrc.
// Data-processing constants are found by a sequential rotation search, one rotation per clock.
module imm_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic          clk,
    input  logic          reset,
    imm_encoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} stateType;
    typedef enum logic [1:0] {IMM_NONE, IMM_DP, IMM_MEM, IMM_BRANCH} immSrcType;

    localparam logic [3:0] LAST_ROT = 4'(ROT_STEPS - 1);

    stateType    state;
    logic [3:0]  rot;
    logic [31:0] valueReg;
    logic        busyReg;
    logic        doneReg;
    logic        validReg;
    logic [23:0] fieldReg;

    logic [63:0] rotWide;
    logic [31:0] cand;
    logic        nonDpValid;
    logic [23:0] nonDpField;
    immSrcType   reqSrc;

    // Rotating the doubled word left keeps the shift in range for every rot, including 0.
    assign rotWide = {valueReg, valueReg} << {rot, 1'b0};
    assign cand    = rotWide[63:32];
    assign reqSrc  = immSrcType'(bus.ImmSrc);

    // NOTE: every output of a combinational block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        nonDpValid = 1'b0;
        nonDpField = '0;
        case (reqSrc)
            IMM_MEM: begin
                nonDpValid = (bus.Value[31:12] == 20'd0);
                nonDpField = nonDpValid ? {12'd0, bus.Value[11:0]} : 24'd0;
            end
            IMM_BRANCH: begin
                // Word-aligned offset whose sign reaches down to bit 25.
                nonDpValid = (bus.Value[1:0] == 2'b00) &&
                             ((&bus.Value[31:25]) || !(|bus.Value[31:25]));
                nonDpField = nonDpValid ? bus.Value[25:2] : 24'd0;
            end
            default: begin
                nonDpValid = 1'b0;
                nonDpField = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rot      <= '0;
            valueReg <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            validReg <= 1'b0;
            fieldReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        valueReg <= bus.Value;
                        rot      <= '0;
                        busyReg  <= 1'b1;
                        if (reqSrc == IMM_DP) begin
                            state <= SEARCH;
                        end else begin
                            state    <= DONE;
                            doneReg  <= 1'b1;
                            validReg <= nonDpValid;
                            fieldReg <= nonDpField;
                        end
                    end
                end
                SEARCH: begin
                    if (cand[31:8] == 24'd0) begin
                        state    <= DONE;
                        doneReg  <= 1'b1;
                        validReg <= 1'b1;
                        fieldReg <= {12'd0, rot, cand[7:0]};
                    end else if (rot == LAST_ROT) begin
                        state    <= DONE;
                        doneReg  <= 1'b1;
                        validReg <= 1'b0;
                        fieldReg <= '0;
                    end else begin
                        rot <= rot + 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy  = busyReg;
    assign bus.Done  = doneReg;
    assign bus.Valid = validReg;
    assign bus.Field = fieldReg;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, hand-written busy/reset
// sequences, and random operations compared against an extender-based reference model.
module tb_imm_encoder;

    localparam int ROT_STEPS = 16;
    localparam int MAX_WAIT  = 40;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_DP   = 2'b01;
    localparam logic [1:0] SRC_MEM  = 2'b10;
    localparam logic [1:0] SRC_BR   = 2'b11;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imm_encoder_if bus();

    imm_encoder #(.ROT_STEPS(ROT_STEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  src;
        logic        expValid;
        logic [23:0] expField;
        int          expLat;
    } vecType;

    vecType vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
        if (s == 0) return v;
        return (v >> s) | (v << (32 - s));
    endfunction

    // Reference: a constant is encodable if the extender reproduces it from some field.
    function automatic void refModel(input logic [31:0] v, input logic [1:0] src,
                                     output logic ok, output logic [23:0] fld, output int lat);
        longint sv;
        bit     found;
        ok  = 1'b0;
        fld = '0;
        lat = 1;
        case (src)
            SRC_DP: begin
                found = 1'b0;
                lat   = 1 + ROT_STEPS;
                for (int r = 0; r < ROT_STEPS && !found; r++) begin
                    for (int i = 0; i < 256 && !found; i++) begin
                        if (rotr(32'(i), 2 * r) == v) begin
                            found = 1'b1;
                            ok    = 1'b1;
                            fld   = 24'(r * 256 + i);
                            lat   = 2 + r;
                        end
                    end
                end
            end
            SRC_MEM: begin
                ok  = (v < 32'd4096);
                fld = ok ? 24'(v) : 24'd0;
            end
            SRC_BR: begin
                sv  = longint'($signed(v));
                ok  = (v % 4 == 0) && (sv >= -(64'sd1 << 25)) && (sv < (64'sd1 << 25));
                fld = ok ? 24'(sv / 4) : 24'd0;
            end
            default: begin
                ok  = 1'b0;
                fld = '0;
            end
        endcase
    endfunction

    // Called one step after a rising edge with the DUT idle; returns one step after the
    // edge that takes the DUT back to IDLE. lat = 0 means Done never appeared.
    task automatic runOp(input logic [31:0] v, input logic [1:0] src,
                         output logic gotValid, output logic [23:0] gotField, output int lat);
        bus.Value  = v;
        bus.ImmSrc = src;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start  = 1'b0;
        bus.Value  = $urandom;
        bus.ImmSrc = 2'($urandom_range(0, 3));
        lat = 0;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            if (bus.Done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        gotValid = bus.Valid;
        gotField = bus.Field;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOp(input string name, input logic [31:0] v, input logic [1:0] src,
                           input logic expValid, input logic [23:0] expField, input int expLat);
        logic        gotValid;
        logic [23:0] gotField;
        int          lat;
        runOp(v, src, gotValid, gotField, lat);
        check({name, " latency"}, 32'(lat), 32'(expLat));
        check({name, " valid"}, 32'(gotValid), 32'(expValid));
        check({name, " field"}, 32'(gotField), 32'(expField));
    endtask

    initial begin
        logic        refValid;
        logic [23:0] refField;
        int          refLat;
        int          donePulses;
        logic [31:0] v;
        logic [1:0]  src;

        vecs[0]  = '{32'h000000FF, SRC_DP,   1'b1, 24'h0000FF, 2};
        vecs[1]  = '{32'hFF000000, SRC_DP,   1'b1, 24'h0004FF, 6};
        vecs[2]  = '{32'h00000101, SRC_DP,   1'b0, 24'h000000, 17};
        vecs[3]  = '{32'h000003FC, SRC_DP,   1'b1, 24'h000FFF, 17};
        vecs[4]  = '{32'h00000000, SRC_DP,   1'b1, 24'h000000, 2};
        vecs[5]  = '{32'hFFFFFFF8, SRC_BR,   1'b1, 24'hFFFFFE, 1};
        vecs[6]  = '{32'h02000000, SRC_BR,   1'b0, 24'h000000, 1};
        vecs[7]  = '{32'h00000006, SRC_BR,   1'b0, 24'h000000, 1};
        vecs[8]  = '{32'h01FFFFFC, SRC_BR,   1'b1, 24'h7FFFFF, 1};
        vecs[9]  = '{32'hFE000000, SRC_BR,   1'b1, 24'h800000, 1};
        vecs[10] = '{32'h00000FFF, SRC_MEM,  1'b1, 24'h000FFF, 1};
        vecs[11] = '{32'h00001000, SRC_MEM,  1'b0, 24'h000000, 1};
        vecs[12] = '{32'h12345678, SRC_NONE, 1'b0, 24'h000000, 1};
        vecs[13] = '{32'h000000AB, SRC_MEM,  1'b1, 24'h0000AB, 1};

        reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Value  = '0;
        bus.ImmSrc = SRC_NONE;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",  32'(bus.Busy),  32'd0);
        check("reset done",  32'(bus.Done),  32'd0);
        check("reset valid", 32'(bus.Valid), 32'd0);
        check("reset field", 32'(bus.Field), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < $size(vecs); i++) begin
            checkOp($sformatf("vec%0d", i), vecs[i].value, vecs[i].src,
                    vecs[i].expValid, vecs[i].expField, vecs[i].expLat);
        end

        // Result holds through idle cycles after a completion.
        checkOp("hold setup", 32'hFF000000, SRC_DP, 1'b1, 24'h0004FF, 6);
        repeat (3) @(posedge clk);
        #1;
        check("hold valid", 32'(bus.Valid), 32'd1);
        check("hold field", 32'(bus.Field), 32'h0004FF);

        // Busy across a full miss search; a Start mid-search must be ignored.
        bus.Value  = 32'h00000101;
        bus.ImmSrc = SRC_DP;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        donePulses = 0;
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("miss busy c%0d", c), 32'(bus.Busy), 32'd1);
            if (c == 17) begin
                check("miss done", 32'(bus.Done), 32'd1);
                check("miss valid", 32'(bus.Valid), 32'd0);
                check("miss field", 32'(bus.Field), 32'd0);
            end else if (bus.Done === 1'b1) begin
                donePulses++;
            end
            bus.Start  = (c == 5 || c == 17);
            bus.Value  = 32'h000000FF;
            bus.ImmSrc = SRC_DP;
            @(posedge clk);
            #1;
        end
        bus.Start = 1'b0;
        check("miss early done", 32'(donePulses), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("no queue busy %0d", c), 32'(bus.Busy), 32'd0);
            @(posedge clk);
            #1;
        end

        // Reset mid-search aborts without a Done pulse.
        checkOp("pre-reset", 32'h000000FF, SRC_DP, 1'b1, 24'h0000FF, 2);
        bus.Value  = 32'h00000101;
        bus.ImmSrc = SRC_DP;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort busy",  32'(bus.Busy),  32'd0);
        check("abort done",  32'(bus.Done),  32'd0);
        check("abort valid", 32'(bus.Valid), 32'd0);
        check("abort field", 32'(bus.Field), 32'd0);
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        reset     = 1'b0;
        donePulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) donePulses++;
            @(posedge clk);
            #1;
        end
        check("abort no activity", 32'(donePulses), 32'd0);
        checkOp("post-reset", 32'hFF000000, SRC_DP, 1'b1, 24'h0004FF, 6);

        // Random operations against the reference model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = rotr(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                2: v = 32'($urandom_range(0, 8191));
                default: v = 32'($signed(26'($urandom))) & ~32'($urandom_range(0, 1));
            endcase
            src = 2'($urandom_range(0, 3));
            refModel(v, src, refValid, refField, refLat);
            checkOp($sformatf("rnd%0d v=%08h src=%0d", n, v, src), v, src, refValid, refField, refLat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
